lfsr_stream_checker: RTL and testbench

LFSR_STREAM_CHECKER -- requirements
Module: lfsr_stream_checker

---
 rtl/lfsr_stream_checker_pkg.sv | 26 ++
 rtl/lfsr12_step.sv | 27 ++
 rtl/lfsr_stream_checker.sv | 157 +++++++++++++++
 tb/tb_lfsr_stream_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_stream_checker_pkg.sv
// ============================================================================
// Module   : lfsr_stream_checker_pkg
// Brief    : Shared LFSR width, tap positions and checker FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_stream_checker_pkg;

    localparam int unsigned c_LFSR_W = 12;
    localparam int unsigned c_CNT_W  = 16;

    // Feedback taps (besides bit 0, which always takes the MSB)
    localparam int unsigned c_TAP_A = 1;
    localparam int unsigned c_TAP_B = 4;
    localparam int unsigned c_TAP_C = 7;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCK    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lfsr12_step.sv
// ============================================================================
// Module   : lfsr12_step
// Brief    : Combinational single-step advance of the 12-bit Galois LFSR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr12_step
    import lfsr_stream_checker_pkg::*;
(
    input  logic [c_LFSR_W-1:0] i_state,
    output logic [c_LFSR_W-1:0] o_state
);

    assign o_state[0] = i_state[c_LFSR_W-1];

    for (genvar k = 1; k < c_LFSR_W; k++) begin : g_bit
        if (k == c_TAP_A || k == c_TAP_B || k == c_TAP_C) begin : g_tap
            assign o_state[k] = i_state[k-1] ^ i_state[c_LFSR_W-1];
        end else begin : g_shift
            assign o_state[k] = i_state[k-1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/lfsr_stream_checker.sv
// ============================================================================
// Module   : lfsr_stream_checker
// Brief    : Locks onto a received LFSR state stream and counts errors in lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_stream_checker
    import lfsr_stream_checker_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 4,
    parameter int unsigned LOSS_MISSES  = 3
)(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [c_LFSR_W-1:0] WORD_IN,
    input  logic                WORD_VALID,
    input  logic                CLEAR_COUNT,
    output logic                LOCKED,
    output logic                ERR_PULSE,
    output logic                ZERO_SEEN,
    output logic [c_CNT_W-1:0]  ERR_COUNT,
    output logic [c_LFSR_W-1:0] EXPECTED_OUT
);

    localparam logic [2:0]         c_LOCK_MATCHES = 3'(LOCK_MATCHES);
    localparam logic [2:0]         c_LOSS_MISSES  = 3'(LOSS_MISSES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX      = '1;

    state_t                r_state;
    logic [c_LFSR_W-1:0]   r_expected;
    logic [2:0]            r_match_cnt;
    logic [2:0]            r_miss_cnt;
    logic                  r_locked;
    logic                  r_err_pulse;
    logic                  r_zero_seen;
    logic [c_CNT_W-1:0]    r_err_count;

    state_t                w_state_nxt;
    logic [c_LFSR_W-1:0]   w_expected_nxt;
    logic [2:0]            w_match_nxt;
    logic [2:0]            w_miss_nxt;
    logic                  w_err;
    logic                  w_zero;
    logic [2:0]            w_match_inc;
    logic [2:0]            w_miss_inc;
    logic                  w_word_zero;
    logic                  w_word_match;
    logic [c_LFSR_W-1:0]   w_step_word;
    logic [c_LFSR_W-1:0]   w_step_exp;

    // Reseed path predicts from the received word, flywheel path from EXPECTED
    lfsr12_step u_step_reseed (
        .i_state (WORD_IN),
        .o_state (w_step_word)
    );

    lfsr12_step u_step_fly (
        .i_state (r_expected),
        .o_state (w_step_exp)
    );

    assign w_match_inc  = r_match_cnt + 3'd1;
    assign w_miss_inc   = r_miss_cnt + 3'd1;
    assign w_word_zero  = (WORD_IN == '0);
    assign w_word_match = (WORD_IN == r_expected);

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_match_nxt    = r_match_cnt;
        w_miss_nxt     = r_miss_cnt;
        w_err          = 1'b0;
        w_zero         = 1'b0;
        if (WORD_VALID) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_word_zero) begin
                        w_zero = 1'b1;
                    end else begin
                        w_expected_nxt = w_step_word;
                        w_match_nxt    = 3'd0;
                        w_state_nxt    = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (w_word_match) begin
                        w_expected_nxt = w_step_word;
                        w_match_nxt    = w_match_inc;
                        if (w_match_inc == c_LOCK_MATCHES) begin
                            w_state_nxt = ST_LOCK;
                            w_miss_nxt  = 3'd0;
                        end
                    end else if (w_word_zero) begin
                        w_state_nxt = ST_HUNT;
                        w_zero      = 1'b1;
                    end else begin
                        w_expected_nxt = w_step_word;
                        w_match_nxt    = 3'd0;
                    end
                end
                ST_LOCK: begin
                    // Flywheel: keep predicting regardless of received content
                    w_expected_nxt = w_step_exp;
                    if (w_word_match) begin
                        w_miss_nxt = 3'd0;
                    end else begin
                        w_err      = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == c_LOSS_MISSES) begin
                            w_state_nxt = ST_HUNT;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_HUNT;
            r_expected  <= '0;
            r_match_cnt <= 3'd0;
            r_miss_cnt  <= 3'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_zero_seen <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == ST_LOCK);
            r_err_pulse <= w_err;
            r_zero_seen <= w_zero;
            // A clear coincident with an error keeps that error counted
            if (CLEAR_COUNT) begin
                r_err_count <= w_err ? c_CNT_W'(1) : '0;
            end else if (w_err && (r_err_count != c_CNT_MAX)) begin
                r_err_count <= r_err_count + c_CNT_W'(1);
            end
        end
    end

    assign LOCKED       = r_locked;
    assign ERR_PULSE    = r_err_pulse;
    assign ZERO_SEEN    = r_zero_seen;
    assign ERR_COUNT    = r_err_count;
    assign EXPECTED_OUT = r_expected;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_stream_checker.sv
// ============================================================================
// Module   : tb_lfsr_stream_checker
// Brief    : Scoreboard bench for lfsr_stream_checker (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_stream_checker;

    logic        CLK;
    logic        RESET;
    logic [11:0] WORD_IN;
    logic        WORD_VALID;
    logic        CLEAR_COUNT;
    logic        LOCKED;
    logic        ERR_PULSE;
    logic        ZERO_SEEN;
    logic [15:0] ERR_COUNT;
    logic [11:0] EXPECTED_OUT;

    // Second instance with a looser loss threshold for the saturation run
    logic        s_reset;
    logic [11:0] s_word;
    logic        s_valid;
    logic        s_clear;
    logic        s_locked;
    logic        s_err;
    logic        s_zero;
    logic [15:0] s_count;
    logic [11:0] s_exp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        locked;
        logic        err;
        logic        zero;
        logic [15:0] cnt;
        logic [11:0] exp_w;
        bit          chk_exp;
        string       name;
    } exp_t;

    exp_t q[$];

    lfsr_stream_checker dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .WORD_IN      (WORD_IN),
        .WORD_VALID   (WORD_VALID),
        .CLEAR_COUNT  (CLEAR_COUNT),
        .LOCKED       (LOCKED),
        .ERR_PULSE    (ERR_PULSE),
        .ZERO_SEEN    (ZERO_SEEN),
        .ERR_COUNT    (ERR_COUNT),
        .EXPECTED_OUT (EXPECTED_OUT)
    );

    lfsr_stream_checker #(.LOCK_MATCHES(4), .LOSS_MISSES(7)) dut_sat (
        .CLK          (CLK),
        .RESET        (s_reset),
        .WORD_IN      (s_word),
        .WORD_VALID   (s_valid),
        .CLEAR_COUNT  (s_clear),
        .LOCKED       (s_locked),
        .ERR_PULSE    (s_err),
        .ZERO_SEEN    (s_zero),
        .ERR_COUNT    (s_count),
        .EXPECTED_OUT (s_exp)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Generator model: shift left, fold polynomial 0x093 in when the MSB leaves
    function automatic logic [11:0] gstep(input logic [11:0] s);
        logic [11:0] t;
        t = {s[10:0], 1'b0};
        if (s[11]) t = t ^ 12'h093;
        return t;
    endfunction

    task automatic send(input bit v, input logic [11:0] w, input bit clr,
                        input logic l, input logic e, input logic z,
                        input logic [15:0] c, input logic [11:0] x,
                        input bit cx, input string nm);
        exp_t it;
        @(negedge CLK);
        WORD_VALID  = v;
        WORD_IN     = w;
        CLEAR_COUNT = clr;
        it.locked  = l;
        it.err     = e;
        it.zero    = z;
        it.cnt     = c;
        it.exp_w   = x;
        it.chk_exp = cx;
        it.name    = nm;
        q.push_back(it);
    endtask

    // Monitor: every entry pushed before an edge describes the outputs after it
    initial begin
        exp_t cur;
        forever begin
            @(posedge CLK);
            if (q.size() > 0) begin
                cur = q.pop_front();
                #1;
                chk({cur.name, ".locked"}, 32'(LOCKED), 32'(cur.locked));
                chk({cur.name, ".err"},    32'(ERR_PULSE), 32'(cur.err));
                chk({cur.name, ".zero"},   32'(ZERO_SEEN), 32'(cur.zero));
                chk({cur.name, ".count"},  32'(ERR_COUNT), 32'(cur.cnt));
                if (cur.chk_exp)
                    chk({cur.name, ".expected"}, 32'(EXPECTED_OUT), 32'(cur.exp_w));
            end
        end
    end

    task automatic sat_word(input logic [11:0] w, input bit clr);
        @(negedge CLK);
        s_valid = 1'b1;
        s_word  = w;
        s_clear = clr;
    endtask

    initial begin
        logic [11:0] gen;
        int          errs;
        int          run;

        RESET = 1'b1; WORD_IN = '0; WORD_VALID = 1'b0; CLEAR_COUNT = 1'b0;
        s_reset = 1'b1; s_word = '0; s_valid = 1'b0; s_clear = 1'b0;

        #12;
        chk("reset.locked",   32'(LOCKED), 0);
        chk("reset.err",      32'(ERR_PULSE), 0);
        chk("reset.zero",     32'(ZERO_SEEN), 0);
        chk("reset.count",    32'(ERR_COUNT), 0);
        chk("reset.expected", 32'(EXPECTED_OUT), 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Acquisition
        send(1, 12'h400, 0, 0, 0, 0, 16'd0, 12'h800, 1, "hunt_seed");
        send(1, 12'h800, 0, 0, 0, 0, 16'd0, 12'h093, 1, "confirm1");
        send(1, 12'h093, 0, 0, 0, 0, 16'd0, 12'h126, 1, "confirm2");
        send(1, 12'h126, 0, 0, 0, 0, 16'd0, 12'h24C, 1, "confirm3");
        send(1, 12'h24C, 0, 1, 0, 0, 16'd0, 12'h498, 1, "lock_rise");
        // Single error in lock
        send(1, 12'h498, 0, 1, 0, 0, 16'd0, 12'h930, 1, "lock_clean");
        send(1, 12'h931, 0, 1, 1, 0, 16'd1, 12'h2F3, 1, "lock_err1");
        send(1, 12'h2F3, 0, 1, 0, 0, 16'd1, 12'h5E6, 1, "after_err_clean");
        send(0, 12'h000, 0, 1, 0, 0, 16'd1, 12'h5E6, 1, "idle_hold");
        send(0, 12'h000, 1, 1, 0, 0, 16'd0, 12'h5E6, 1, "clear_alone");
        // Three consecutive errors drop lock
        send(1, 12'h5E7, 0, 1, 1, 0, 16'd1, 12'hBCC, 1, "miss1");
        send(1, 12'hBCD, 0, 1, 1, 0, 16'd2, 12'h70B, 1, "miss2");
        send(1, 12'h70A, 0, 0, 1, 0, 16'd3, 12'hE16, 1, "miss3_unlock");
        // Zero handling in HUNT and CONFIRM
        send(1, 12'h000, 0, 0, 0, 1, 16'd3, 12'hE16, 1, "hunt_zero");
        send(0, 12'h000, 0, 0, 0, 0, 16'd3, 12'hE16, 1, "zero_once");
        send(1, 12'h001, 0, 0, 0, 0, 16'd3, 12'h002, 1, "hunt_seed1");
        send(1, 12'h005, 0, 0, 0, 0, 16'd3, 12'h00A, 1, "confirm_reseed");
        send(1, 12'h000, 0, 0, 0, 1, 16'd3, 12'h000, 0, "confirm_zero");
        // Reacquire, then clear coincident with an error
        send(1, 12'h400, 0, 0, 0, 0, 16'd3, 12'h800, 1, "relock_seed");
        send(1, 12'h800, 0, 0, 0, 0, 16'd3, 12'h093, 1, "relock1");
        send(1, 12'h093, 0, 0, 0, 0, 16'd3, 12'h126, 1, "relock2");
        send(1, 12'h126, 0, 0, 0, 0, 16'd3, 12'h24C, 1, "relock3");
        send(1, 12'h24C, 0, 1, 0, 0, 16'd3, 12'h498, 1, "relock_rise");
        send(1, 12'h499, 1, 1, 1, 0, 16'd1, 12'h930, 1, "clear_with_err");

        // Asynchronous reset between edges while locked
        @(posedge CLK);
        #3;
        WORD_VALID  = 1'b0;
        CLEAR_COUNT = 1'b0;
        RESET       = 1'b1;
        #1;
        chk("async_reset.locked",   32'(LOCKED), 0);
        chk("async_reset.count",    32'(ERR_COUNT), 0);
        chk("async_reset.expected", 32'(EXPECTED_OUT), 0);
        @(negedge CLK);
        RESET = 1'b0;
        send(1, 12'h930, 0, 0, 0, 0, 16'd0, 12'h2F3, 1, "post_reset_hunt");
        send(1, 12'h2F3, 0, 0, 0, 0, 16'd0, 12'h5E6, 1, "post_reset_no_lock");
        @(negedge CLK);
        WORD_VALID = 1'b0;
        @(posedge CLK);
        #2;

        // Saturation run on the second instance
        @(negedge CLK);
        s_reset = 1'b0;
        sat_word(12'h400, 0);
        sat_word(12'h800, 0);
        sat_word(12'h093, 0);
        sat_word(12'h126, 0);
        sat_word(12'h24C, 0);
        gen  = 12'h498;
        errs = 0;
        run  = 0;
        while (errs < 65535) begin
            if (run == 6) begin
                sat_word(gen, 0);
                run = 0;
            end else begin
                sat_word(gen ^ 12'h001, 0);
                run++;
                errs++;
            end
            gen = gstep(gen);
        end
        sat_word(gen, 0);
        gen = gstep(gen);
        @(posedge CLK); #1;
        chk("sat_preload.count",  32'(s_count), 32'hFFFF);
        chk("sat_preload.locked", 32'(s_locked), 1);
        sat_word(gen ^ 12'h001, 0);
        gen = gstep(gen);
        @(posedge CLK); #1;
        chk("sat_hold.count", 32'(s_count), 32'hFFFF);
        chk("sat_hold.err",   32'(s_err), 1);
        sat_word(gen ^ 12'h001, 1);
        @(posedge CLK); #1;
        chk("sat_clear_err.count", 32'(s_count), 1);
        chk("sat_clear_err.locked", 32'(s_locked), 1);
        @(negedge CLK);
        s_valid = 1'b0;
        s_clear = 1'b0;

        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
